tmds_encoder_multi: RTL and testbench

Parametrised multi-channel TMDS encoder: converts per-channel 8-bit pixel data, 2-bit control, or 4-bit auxiliary (TERC4) nibbles into 10-bit TMDS symbols for the serialiser. It extends the stage-1 transition-minimisation choice with stage-2 DC balancing, using a running signed disparity counter per channel, plus control-period and data-island modes. The block sits between the video timing/pixel path and the 10:1 serialisers, one pixel-clock domain.

---
 rtl/tmds_pkg.sv | 66 ++++++
 rtl/tmds_channel.sv | 73 +++++++
 rtl/tmds_encoder_multi.sv | 35 +++
 tb/tb_tmds_encoder_multi.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS modes, control tokens and encoding helper functions
// Provides: tmds_mode_e, TMDS_CNT_W, TMDS_CTRL_xx tokens, count_ones, tmds_qm, ctrl_token, terc4
package tmds_pkg;

    localparam int TMDS_CNT_W = 6;

    typedef enum logic [1:0] {
        TMDS_CONTROL = 2'd0,
        TMDS_VIDEO   = 2'd1,
        TMDS_TERC4   = 2'd2
    } tmds_mode_e;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Stage-1 transition minimisation; bit 8 set means the XOR chain was used
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n;
        logic       x;
        logic [8:0] q;
        n = count_ones(d);
        x = n > 4'd4 || (n == 4'd4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
        q[8] = ~x;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        return c == 2'b00 ? TMDS_CTRL_00 : c == 2'b01 ? TMDS_CTRL_01 :
               c == 2'b10 ? TMDS_CTRL_10 : TMDS_CTRL_11;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'ha: s = 10'b0110011100;
            4'hb: s = 10'b1011000110;
            4'hc: s = 10'b1010001110;
            4'hd: s = 10'b1001110001;
            4'he: s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// tmds_channel: one TMDS channel, stage-1 q_m register and stage-2 DC-balanced output with disparity counter
// Ports: clk_in/rst_n_in/en_in clock, async low reset, enable; mode_in shared mode;
//        data_in/ctrl_in/aux_in channel inputs; tmds_out 10-bit symbol; disparity_out signed counter
module tmds_channel
    import tmds_pkg::*;
#(
    parameter int CNT_W = TMDS_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic [1:0]       mode_in,
    input  logic [7:0]       data_in,
    input  logic [1:0]       ctrl_in,
    input  logic [3:0]       aux_in,
    output logic [9:0]       tmds_out,
    output logic [CNT_W-1:0] disparity_out
);

    tmds_mode_e              mode_d, mode_q;
    logic [8:0]              qm_d, qm_q;
    logic [3:0]              n1q_d, n1q_q;
    logic [1:0]              ctrl_q;
    logic [3:0]              aux_q;
    logic [9:0]              tmds_d, tmds_q, vid_sym;
    logic signed [CNT_W-1:0] cnt_d, cnt_q, vid_cnt, diff, two;
    logic                    bal, inv;

    always_comb begin
        qm_d   = tmds_qm(data_in);
        n1q_d  = count_ones(qm_d[7:0]);
        mode_d = mode_in == 2'd1 ? TMDS_VIDEO : mode_in == 2'd2 ? TMDS_TERC4 : TMDS_CONTROL;
    end

    // diff is N1q - N0q = 2*N1q - 8; bal has priority so inv only sees cnt != 0
    always_comb begin
        diff    = CNT_W'({n1q_q, 1'b0}) - CNT_W'(8);
        two     = CNT_W'(2);
        bal     = cnt_q == '0 || n1q_q == 4'd4;
        inv     = (!cnt_q[CNT_W-1] && n1q_q > 4'd4) || (cnt_q[CNT_W-1] && n1q_q < 4'd4);
        vid_sym = bal ? {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]}
                      : {inv, qm_q[8], inv ? ~qm_q[7:0] : qm_q[7:0]};
        vid_cnt = bal ? (qm_q[8] ? cnt_q + diff : cnt_q - diff)
                : inv ? cnt_q - diff + (qm_q[8] ? two : '0)
                      : cnt_q + diff - (qm_q[8] ? '0 : two);
        tmds_d  = mode_q == TMDS_VIDEO ? vid_sym : mode_q == TMDS_TERC4 ? terc4(aux_q) : ctrl_token(ctrl_q);
        cnt_d   = mode_q == TMDS_VIDEO ? vid_cnt : '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q <= TMDS_CONTROL;
            qm_q   <= '0;
            n1q_q  <= '0;
            ctrl_q <= '0;
            aux_q  <= '0;
            tmds_q <= TMDS_CTRL_00;
            cnt_q  <= '0;
        end else if (en_in) begin
            mode_q <= mode_d;
            qm_q   <= qm_d;
            n1q_q  <= n1q_d;
            ctrl_q <= ctrl_in;
            aux_q  <= aux_in;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_out      = tmds_q;
    assign disparity_out = cnt_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi: NUM_CH independent TMDS channel encoders sharing one mode
// Ports: clk_in/rst_n_in/en_in clock, async low reset, enable; mode_in shared mode;
//        data_in/ctrl_in/aux_in packed per channel; tmds_out and disparity_out packed per channel
module tmds_encoder_multi
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = TMDS_CNT_W
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    en_in,
    input  logic [1:0]              mode_in,
    input  logic [NUM_CH*8-1:0]     data_in,
    input  logic [NUM_CH*2-1:0]     ctrl_in,
    input  logic [NUM_CH*4-1:0]     aux_in,
    output logic [NUM_CH*10-1:0]    tmds_out,
    output logic [NUM_CH*CNT_W-1:0] disparity_out
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_in        (clk_in),
            .rst_n_in      (rst_n_in),
            .en_in         (en_in),
            .mode_in       (mode_in),
            .data_in       (data_in[8*k +: 8]),
            .ctrl_in       (ctrl_in[2*k +: 2]),
            .aux_in        (aux_in[4*k +: 4]),
            .tmds_out      (tmds_out[10*k +: 10]),
            .disparity_out (disparity_out[CNT_W*k +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// tb_tmds_encoder_multi: vector table, hand sequences and randomized model check of tmds_encoder_multi
module tb_tmds_encoder_multi;

    localparam int NCH = 4;
    localparam int CW  = 6;

    logic              clk = 0, rst_n = 0, en = 0;
    logic [1:0]        mode = 0;
    logic [NCH*8-1:0]  data = 0;
    logic [NCH*2-1:0]  ctrl = 0;
    logic [NCH*4-1:0]  aux = 0;
    logic [NCH*10-1:0] tmds;
    logic [NCH*CW-1:0] disp;

    int total = 0, bad = 0;

    tmds_encoder_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(mode),
        .data_in(data), .ctrl_in(ctrl), .aux_in(aux),
        .tmds_out(tmds), .disparity_out(disp)
    );

    always #5 clk = ~clk;

    logic [9:0] terc[16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                             10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                             10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                             10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] ctl[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    int         cnt_m[NCH], pend_cnt[NCH], out_cnt[NCH];
    logic [9:0] pend_sym[NCH], out_sym[NCH];

    function automatic int ones8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic encode(input int ch, input logic [1:0] m, input logic [7:0] d,
                          input logic [1:0] c, input logic [3:0] a, output logic [9:0] s);
        logic [8:0] q;
        int n, n1, n0;
        bit x;
        if (m == 2'd1) begin
            n = ones8(d);
            x = n > 4 || (n == 4 && d[0] == 1'b0);
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            q[8] = !x;
            n1 = ones8(q[7:0]);
            n0 = 8 - n1;
            if (cnt_m[ch] == 0 || n1 == n0) begin
                s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                cnt_m[ch] += q[8] ? n1 - n0 : n0 - n1;
            end else if ((cnt_m[ch] > 0 && n1 > n0) || (cnt_m[ch] < 0 && n0 > n1)) begin
                s = {1'b1, q[8], ~q[7:0]};
                cnt_m[ch] += 2 * int'(q[8]) + n0 - n1;
            end else begin
                s = {1'b0, q[8], q[7:0]};
                cnt_m[ch] += n1 - n0 - 2 * int'(!q[8]);
            end
        end else if (m == 2'd2) begin
            s = terc[a];
            cnt_m[ch] = 0;
        end else begin
            s = ctl[c];
            cnt_m[ch] = 0;
        end
    endtask

    task automatic reset_model();
        for (int ch = 0; ch < NCH; ch++) begin
            cnt_m[ch] = 0; pend_cnt[ch] = 0; out_cnt[ch] = 0;
            pend_sym[ch] = ctl[0]; out_sym[ch] = ctl[0];
        end
    endtask

    // Symbols are computed in input order; the two-edge pipeline is a delay line
    task automatic model_edge();
        if (en)
            for (int ch = 0; ch < NCH; ch++) begin
                out_sym[ch] = pend_sym[ch];
                out_cnt[ch] = pend_cnt[ch];
                encode(ch, mode, data[8*ch +: 8], ctrl[2*ch +: 2], aux[4*ch +: 4], pend_sym[ch]);
                pend_cnt[ch] = cnt_m[ch];
            end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input int ch, input logic [9:0] et, input int ec);
        logic [9:0] gt;
        int         gc;
        gt = tmds[10*ch +: 10];
        gc = $signed(disp[CW*ch +: CW]);
        total += 2;
        if (gt !== et) begin
            bad++;
            $display("FAIL %s ch%0d tmds got %b want %b", name, ch, gt, et);
        end
        if (gc != ec) begin
            bad++;
            $display("FAIL %s ch%0d disparity got %0d want %0d", name, ch, gc, ec);
        end
    endtask

    task automatic set_all(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c, input logic [3:0] a);
        mode = m;
        for (int ch = 0; ch < NCH; ch++) begin
            data[8*ch +: 8] = d; ctrl[2*ch +: 2] = c; aux[4*ch +: 4] = a;
        end
    endtask

    typedef struct {
        logic [1:0] m;
        logic [7:0] d;
        logic [1:0] c;
        logic [3:0] a;
        logic [9:0] t;
        int         n;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{2'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -8};
        tv[1]  = '{2'd1, 8'h00, 2'd0, 4'h0, 10'b1111111111,  2};
        tv[2]  = '{2'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -6};
        tv[3]  = '{2'd0, 8'h00, 2'd2, 4'h0, 10'b0101010100,  0};
        tv[4]  = '{2'd1, 8'hff, 2'd0, 4'h0, 10'b1000000000, -8};
        tv[5]  = '{2'd0, 8'h00, 2'd1, 4'h0, 10'b0010101011,  0};
        tv[6]  = '{2'd0, 8'h00, 2'd3, 4'h0, 10'b1010101011,  0};
        tv[7]  = '{2'd0, 8'h00, 2'd0, 4'h0, 10'b1101010100,  0};
        tv[8]  = '{2'd1, 8'h00, 2'd0, 4'h0, 10'b0100000000, -8};
        tv[9]  = '{2'd2, 8'h00, 2'd0, 4'h0, 10'b1010011100,  0};
        tv[10] = '{2'd2, 8'h00, 2'd0, 4'hf, 10'b1011000011,  0};
        tv[11] = '{2'd3, 8'h00, 2'd0, 4'h0, 10'b1101010100,  0};

        reset_model();
        #12;
        for (int ch = 0; ch < NCH; ch++) chk("reset", ch, 10'b1101010100, 0);
        en = 1;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 12; i++) begin
            set_all(tv[i].m, tv[i].d, tv[i].c, tv[i].a);
            tick();
            for (int ch = 0; ch < NCH; ch++)
                if (i == 0) chk("first_edge", ch, 10'b1101010100, 0);
                else chk("vec", ch, tv[i-1].t, tv[i-1].n);
        end
        set_all(2'd0, 8'h00, 2'd0, 4'h0);
        tick();
        for (int ch = 0; ch < NCH; ch++) chk("vec_last", ch, tv[11].t, tv[11].n);

        mode = 2'd2;
        aux = {4'ha, 4'hf, 4'h0, 4'h5};
        tick();
        tick();
        chk("terc4", 0, 10'b0100011110, 0);
        chk("terc4", 1, 10'b1010011100, 0);
        chk("terc4", 2, 10'b1011000011, 0);
        chk("terc4", 3, 10'b0110011100, 0);

        set_all(2'd1, 8'h00, 2'd0, 4'h0);
        tick();
        tick();
        for (int ch = 0; ch < NCH; ch++) chk("pre_hold", ch, 10'b0100000000, -8);
        en = 0;
        set_all(2'd1, 8'hff, 2'd0, 4'h0);
        for (int j = 0; j < 3; j++) begin
            tick();
            for (int ch = 0; ch < NCH; ch++) chk("hold", ch, 10'b0100000000, -8);
        end
        en = 1;
        tick();
        for (int ch = 0; ch < NCH; ch++) chk("resume", ch, 10'b1111111111, 2);

        set_all(2'd1, 8'h00, 2'd0, 4'h0);
        tick();
        #3;
        rst_n = 0;
        #1;
        for (int ch = 0; ch < NCH; ch++) chk("async_reset", ch, 10'b1101010100, 0);
        reset_model();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            int r;
            en = i[0];
            r = $urandom_range(0, 9);
            mode = r < 6 ? 2'd1 : r == 6 ? 2'd0 : r == 7 ? 2'd2 : r == 8 ? 2'd3 : 2'd0;
            data = $urandom;
            ctrl = 8'($urandom);
            aux = 16'($urandom);
            tick();
            for (int ch = 0; ch < NCH; ch++) chk("random", ch, out_sym[ch], out_cnt[ch]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
